ifetch_queue: RTL and testbench
===============================

// Module: ifetch_queue
// PURPOSE
//  Parametrised instruction-fetch front end with a prefetch queue. Successor to the single-cycle fetch path.
//  Streams sequential requests to a pipelined instruction memory and buffers {pc, instr} pairs for decode
//  under a valid/ready handshake. Handles branch redirect (flush) and halt.
//  Sits between instruction memory and the decode stage of the pipelined core.
// PARAMETERS
//  INSTR_W   16  instruction width (bits)
//  ADDR_W    16  word address width; PC counts in words
//  DEPTH     4   queue entries; power of 2, >=2
//  RESET_PC  0   fetch PC after reset
// PORTS
//  clk          in   1        sole clock, rising edge
//  rst          in   1        synchronous, active-high reset
//  imem_req     out  1        fetch request this cycle
//  imem_addr    out  ADDR_W   fetch word address (= fetch_pc)
//  imem_rdata   in   INSTR_W  returned instruction
//  imem_valid   in   1        response valid; exactly 1 cycle after its imem_req
//  instr_valid  out  1        queue head valid toward decode
//  instr        out  INSTR_W  head instruction
//  instr_pc     out  ADDR_W   head instruction address
//  instr_ready  in   1        decode accepts head this cycle
//  br_ctrl      in   1        redirect/flush request
//  new_pc       in   ADDR_W   redirect target
//  hlt          in   1        level; stop issuing new fetches
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, count=0, inflight=0, storage cleared.
//   Outputs in the reset cycle and the cycle after: imem_req=0, imem_addr=RESET_PC, instr_valid=0,
//   instr=0, instr_pc=0.
//  issue = !rst & !hlt & !br_ctrl & (count + inflight < DEPTH). Combinational only.
//   imem_req = issue. On issue: fetch_pc <= fetch_pc+1, modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
//   inflight <= issue (memory latency is fixed at 1).
//  push = imem_valid & !br_ctrl. Push writes {pc_of_request, imem_rdata} at the tail.
//   The pc register holds the address of the last issued request.
//  pop = instr_valid & instr_ready. Push and pop in the same cycle: count unchanged, both occur.
//  Full: count==DEPTH. The credit rule makes a push while full impossible. The bench asserts this never happens.
//  Empty: instr_valid=0; instr/instr_pc hold the last value (don't-care).
//  Redirect, br_ctrl=1 in cycle t (highest priority):
//   - Clear the queue (count=0).
//   - Discard any response arriving in t.
//   - Issue no request in t; fetch_pc <= new_pc.
//   - pop is ignored.
//   - t+1: imem_req for new_pc. t+2: response pushed. t+3: instr_valid=1, instr_pc=new_pc (non-bypass).
//  Back-to-back br_ctrl: the last one wins; no request issues while br_ctrl is held.
//  hlt=1: no new requests. An in-flight response is still pushed. The queue keeps draining to decode.
//   hlt=0: issuing resumes at fetch_pc.
//  rst mid-operation: everything is discarded. A response arriving in the cycle after rst deasserts is dropped
//   (inflight=0).
//  Throughput: 1 instr/cycle sustained with instr_ready=1. Latency imem_valid -> instr_valid: 1 cycle.
// CONFIGURATION
//  IFQ_BYPASS_EN defined: when count==0 and push, the response drives instr/instr_pc/instr_valid combinationally
//   in the same cycle.
//   - If instr_ready=1, the word is consumed and not enqueued.
//   - Otherwise it is enqueued.
//   - Redirect-to-valid latency becomes t+2.
//  IFQ_BYPASS_EN undefined: registered queue output only, as specified above.
// STRUCTURE
//  Package cpu_pkg:
//   - INSTR_W/ADDR_W defaults, RESET_PC.
//   - typedef ifq_entry_t {pc, instr}.
//  Sub-module ifq_fifo: sync FIFO of ifq_entry_t.
//   - DEPTH parameter; push/pop/flush/count; ptr wrap via power-of-2 index.
//  Top: fetch_pc, inflight flag, issue/credit logic, bypass mux.
// TESTING
//  1 rst then instr_ready=1 -> imem_addr 0,1,2,...; instr_valid first at cycle 2 after the first req;
//    instr_pc 0,1,2 consecutive, no gaps.
//  2 instr_ready=0 from start -> 4 entries queued, imem_req=0 once count+inflight=4.
//    instr_ready=1 -> instr_pc 0..N in order, no loss or duplicate.
//  3 queue holds 3 entries + 1 in flight; br_ctrl=1, new_pc=0x0040 -> next cycle instr_valid=0,
//    in-flight dropped; next valid instr_pc=0x0040 at t+3.
//  4 hlt=1 after req for pc 5 -> no more reqs; pc<=5 drain; then instr_valid=0 steady.
//    hlt=0 -> req pc 6.
//  5 br_ctrl, new_pc=0xFFFF -> instr_pc sequence 0xFFFF, 0x0000, 0x0001.
//  6 rst=1 with full queue -> next cycle instr_valid=0, imem_addr=RESET_PC.
//    Rerun 1 and 3 with IFQ_BYPASS_EN -> valid one cycle earlier.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch front end: default widths,
// reset PC and the {pc, instr} queue entry type.
package cpu_pkg;

    localparam int DEF_INSTR_W  = 16;
    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_RESET_PC = 0;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0]  pc;
        logic [DEF_INSTR_W-1:0] instr;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} entries for decode.
// Power-of-2 depth, so read/write pointers wrap naturally; a flush empties
// the queue in one cycle without touching the stored words.
module ifq_fifo
    import cpu_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = ifq_entry_t,
    localparam int IDX_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  entry_t           wdata,
    output entry_t           head,
    output logic [CNT_W-1:0] count
);

    entry_t           mem [DEPTH];
    logic [IDX_W-1:0] rd_ptr;
    logic [IDX_W-1:0] wr_ptr;

    // Storage, pointers and occupancy; flush outranks push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= rd_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + IDX_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + IDX_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end with a prefetch queue.
// Issues sequential word fetches to a 1-cycle pipelined instruction memory,
// buffers {pc, instr} pairs for decode, and handles redirect and halt.
// Optional feature: define IFQ_BYPASS_EN to let a response reach decode in
// the same cycle it returns whenever the queue is empty.
module ifetch_queue
    import cpu_pkg::*;
#(
    parameter int              INSTR_W  = DEF_INSTR_W,
    parameter int              ADDR_W   = DEF_ADDR_W,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    input  logic               br_ctrl,
    input  logic [ADDR_W-1:0]  new_pc,
    input  logic               hlt
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;
    logic              inflight;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    credit_used;
    entry_t            head;
    entry_t            wdata;
    logic              issue;
    logic              push;
    logic              pop;
    logic              q_empty;
    logic              bypass_hit;
    logic              fifo_push;
    logic              fifo_pop;

    // Credit: queued entries plus the outstanding request never exceed DEPTH,
    // so a returning response always has a free slot.
    assign credit_used = {1'b0, count} + (CNT_W+1)'(inflight);
    assign issue       = !rst && !hlt && !br_ctrl && (credit_used < (CNT_W+1)'(DEPTH));
    assign imem_req    = issue;
    assign imem_addr   = rst ? RESET_PC : fetch_pc;

    // Responses only count when we actually have a request outstanding,
    // and are dropped during a redirect.
    assign push    = imem_valid && inflight && !br_ctrl && !rst;
    assign q_empty = (count == '0);

`ifdef IFQ_BYPASS_EN
    assign bypass_hit = push && q_empty;
`else
    assign bypass_hit = 1'b0;
`endif

    assign pop       = instr_valid && instr_ready && !br_ctrl;
    assign fifo_pop  = pop && !q_empty;
    assign fifo_push = push && !(bypass_hit && instr_ready);

    // Pack the returning word with the address it was fetched from
    always_comb begin
        wdata       = '0;
        wdata.pc    = req_pc;
        wdata.instr = imem_rdata;
    end

    // Decode-facing outputs: bypassed response or registered queue head
    always_comb begin
        instr_valid = 1'b0;
        instr       = '0;
        instr_pc    = '0;
        if (!rst) begin
            if (bypass_hit) begin
                instr_valid = 1'b1;
                instr       = imem_rdata;
                instr_pc    = req_pc;
            end else begin
                instr_valid = !q_empty;
                instr       = head.instr;
                instr_pc    = head.pc;
            end
        end
    end

    // Fetch PC, address of the outstanding request, and the in-flight flag
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (br_ctrl) begin
                fetch_pc <= new_pc;
            end else if (issue) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + ADDR_W'(1);
            end
        end
    end

    ifq_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (br_ctrl),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (wdata),
        .head  (head),
        .count (count)
    );

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed self-checking bench for ifetch_queue with a 1-cycle memory model
// that returns the bitwise inverse of the requested address.
module tb_ifetch_queue;

`ifdef IFQ_BYPASS_EN
    localparam int BP = 1;
`else
    localparam int BP = 0;
`endif

    logic        clk         = 1'b0;
    logic        rst         = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata  = '0;
    logic        imem_valid  = 1'b0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        br_ctrl     = 1'b0;
    logic [15:0] new_pc      = '0;
    logic        hlt         = 1'b0;

    int tests = 0;
    int fails = 0;
    int overflow_hits = 0;

    ifetch_queue dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .br_ctrl     (br_ctrl),
        .new_pc      (new_pc),
        .hlt         (hlt)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Instruction memory: response exactly one cycle after the request
    always @(posedge clk) begin
        imem_valid <= imem_req;
        imem_rdata <= ~imem_addr;
    end

    // Watch for a push into a full queue, which the credit rule forbids
    always @(posedge clk) begin
        if (!rst && dut.count == 3'd4 && dut.fifo_push) begin
            overflow_hits <= overflow_hits + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; instr_ready = 1'b0; br_ctrl = 1'b0; hlt = 1'b0; new_pc = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_ready = 1'b0; br_ctrl = 1'b0; hlt = 1'b0; new_pc = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || instr_valid !== 1'b0 ||
                instr !== 16'h0000 || instr_pc !== 16'h0000) begin
                fails++;
                $display("[TB] FAIL reset_outputs cycle %0d: req=%0b addr=%h valid=%0b instr=%h pc=%h, expected 0 0000 0 0000 0000",
                         i, imem_req, imem_addr, instr_valid, instr, instr_pc);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic        ev;
        logic [15:0] ep;
        reset_dut();
        instr_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            tests++;
            if (imem_req !== 1'b1 || imem_addr !== 16'(k)) begin
                fails++;
                $display("[TB] FAIL stream_req k=%0d: req=%0b addr=%h, expected req=1 addr=%h", k, imem_req, imem_addr, 16'(k));
            end
            ev = (k >= 2 - BP);
            ep = 16'(k - 2 + BP);
            tests++;
            if (instr_valid !== ev || (ev && (instr_pc !== ep || instr !== ~ep))) begin
                fails++;
                $display("[TB] FAIL stream_out k=%0d: valid=%0b pc=%h instr=%h, expected valid=%0b pc=%h instr=%h",
                         k, instr_valid, instr_pc, instr, ev, ep, ~ep);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic ereq;
        reset_dut();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            ereq = (k < 4);
            tests++;
            if (imem_req !== ereq || (ereq && imem_addr !== 16'(k))) begin
                fails++;
                $display("[TB] FAIL bp_req k=%0d: req=%0b addr=%h, expected req=%0b addr=%h", k, imem_req, imem_addr, ereq, 16'(k));
            end
            tick();
        end
        instr_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            tests++;
            if (instr_valid !== 1'b1 || instr_pc !== 16'(j) || instr !== ~16'(j)) begin
                fails++;
                $display("[TB] FAIL bp_drain j=%0d: valid=%0b pc=%h instr=%h, expected 1 pc=%h", j, instr_valid, instr_pc, instr, 16'(j));
            end
            tick();
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_redirect();
        reset_dut();
        for (int k = 0; k < 4; k++) tick();
        @(negedge clk);
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || imem_req !== 1'b0) begin
            fails++;
            $display("[TB] FAIL redir_pre: valid=%0b pc=%h req=%0b, expected 1 0000 0", instr_valid, instr_pc, imem_req);
        end
        br_ctrl = 1'b1; new_pc = 16'h0040;
        @(negedge clk);
        tests++;
        if (imem_req !== 1'b0) begin
            fails++;
            $display("[TB] FAIL redir_t_req: req=%0b, expected 0", imem_req);
        end
        tick();
        br_ctrl = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
            fails++;
            $display("[TB] FAIL redir_t1: valid=%0b req=%0b addr=%h, expected 0 1 0040", instr_valid, imem_req, imem_addr);
        end
        tick();
        @(negedge clk);
        tests++;
        if (instr_valid !== 1'(BP) || (BP == 1 && instr_pc !== 16'h0040)) begin
            fails++;
            $display("[TB] FAIL redir_t2: valid=%0b pc=%h, expected valid=%0d pc=0040", instr_valid, instr_pc, BP);
        end
        tick();
        @(negedge clk);
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'(16'h0040 + BP) || instr !== ~16'(16'h0040 + BP)) begin
            fails++;
            $display("[TB] FAIL redir_t3: valid=%0b pc=%h instr=%h, expected 1 pc=%h", instr_valid, instr_pc, instr, 16'(16'h0040 + BP));
        end
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_halt();
        logic        ev;
        logic [15:0] ep;
        reset_dut();
        instr_ready = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        hlt = 1'b1;
        for (int k = 6; k < 11; k++) begin
            @(negedge clk);
            ev = (k < 8 - BP);
            ep = 16'(k - 2 + BP);
            tests++;
            if (imem_req !== 1'b0 || instr_valid !== ev || (ev && instr_pc !== ep)) begin
                fails++;
                $display("[TB] FAIL halt_drain k=%0d: req=%0b valid=%0b pc=%h, expected req=0 valid=%0b pc=%h",
                         k, imem_req, instr_valid, instr_pc, ev, ep);
            end
            tick();
        end
        hlt = 1'b0;
        @(negedge clk);
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0006) begin
            fails++;
            $display("[TB] FAIL halt_resume: req=%0b addr=%h, expected 1 0006", imem_req, imem_addr);
        end
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic        ev;
        logic [15:0] ep;
        reset_dut();
        instr_ready = 1'b1;
        br_ctrl = 1'b1; new_pc = 16'hFFFF;
        tick();
        br_ctrl = 1'b0;
        @(negedge clk);
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 16'hFFFF) begin
            fails++;
            $display("[TB] FAIL wrap_req0: req=%0b addr=%h, expected 1 FFFF", imem_req, imem_addr);
        end
        tick();
        for (int k = 2; k <= 5 - BP; k++) begin
            @(negedge clk);
            ev = (k >= 3 - BP);
            ep = 16'hFFFF + 16'(k - 3 + BP);
            tests++;
            if (instr_valid !== ev || (ev && instr_pc !== ep)) begin
                fails++;
                $display("[TB] FAIL wrap_seq k=%0d: valid=%0b pc=%h, expected valid=%0b pc=%h", k, instr_valid, instr_pc, ev, ep);
            end
            tick();
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_reset_full();
        reset_dut();
        for (int k = 0; k < 6; k++) tick();
        @(negedge clk);
        tests++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr_pc !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL full_state: valid=%0b req=%0b pc=%h, expected 1 0 0000", instr_valid, imem_req, instr_pc);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL full_rst_cycle: valid=%0b req=%0b addr=%h, expected 0 0 0000", instr_valid, imem_req, imem_addr);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (instr_valid !== 1'b0 || imem_addr !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL full_after_rst: valid=%0b addr=%h, expected 0 0000", instr_valid, imem_addr);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_reset_full();
        tests++;
        if (overflow_hits !== 0) begin
            fails++;
            $display("[TB] FAIL no_push_when_full: hits=%0d, expected 0", overflow_hits);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
